// File: rtl/flag_capture_ctrl.sv
// flag_capture_ctrl: sequences the enable-qualified flag-capture datapath.
// din_async is synchronised and edge-detected. The registered enable en_q
// walks through settle, watch, report and cooldown phases. Each captured rise
// is presented to the consumer over a valid/ack handshake and counted with
// saturation. Rises that arrive while an event is outstanding or cooling down
// are reported as one-cycle miss pulses.
module flag_capture_ctrl #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 3,
    parameter int HOLD_CYCLES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             arm,
    input  logic             din_async,
    input  logic             flag_ack,
    output logic             en_q,
    output logic             flag,
    output logic             flag_valid,
    output logic             miss,
    output logic             busy,
    output logic [CNT_W-1:0] event_cnt
);

    localparam int MAX_CYC = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int TW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WATCH,
        ST_REPORT,
        ST_COOLDOWN
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_din_d;
    logic                   w_din_s;
    logic                   w_rise;
    logic [TW-1:0]          r_cnt;
    logic [TW-1:0]          w_cnt_nxt;
    logic                   r_en_q;
    logic                   r_flag;
    logic                   w_flag_nxt;
    logic                   r_flag_valid;
    logic                   r_miss;
    logic                   w_miss_nxt;
    logic                   r_busy;
    logic [CNT_W-1:0]       r_evt;
    logic [CNT_W-1:0]       w_evt_nxt;

    assign w_din_s = r_sync[SYNC_STAGES-1];
    assign w_rise  = w_din_s & ~r_din_d;

    // Synchroniser chain plus the delay flop used for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync  <= '0;
            r_din_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], din_async};
            r_din_d <= w_din_s;
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_en_q       <= 1'b0;
            r_flag       <= 1'b0;
            r_flag_valid <= 1'b0;
            r_miss       <= 1'b0;
            r_busy       <= 1'b0;
            r_evt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_en_q       <= (w_state_nxt != ST_IDLE);
            r_flag       <= w_flag_nxt;
            r_flag_valid <= w_flag_nxt;
            r_miss       <= w_miss_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_evt        <= w_evt_nxt;
        end
    end

    // Next-state, phase counter, flag and event-count decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_flag_nxt  = r_flag;
        w_evt_nxt   = r_evt;
        w_miss_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (arm) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (!arm) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_WATCH;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_WATCH: begin
                // Disarm wins over a same-cycle rise; that rise is dropped silently.
                if (!arm) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rise) begin
                    w_flag_nxt  = 1'b1;
                    w_state_nxt = ST_REPORT;
                    if (r_evt != '1) begin
                        w_evt_nxt = r_evt + 1'b1;
                    end
                end
            end
            ST_REPORT: begin
                w_miss_nxt = w_rise;
                if (flag_ack && r_flag_valid) begin
                    w_flag_nxt  = 1'b0;
                    w_cnt_nxt   = HOLD_LOAD;
                    w_state_nxt = ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                w_miss_nxt = w_rise;
                if (r_cnt == '0) begin
                    w_state_nxt = arm ? ST_WATCH : ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign en_q       = r_en_q;
    assign flag       = r_flag;
    assign flag_valid = r_flag_valid;
    assign miss       = r_miss;
    assign busy       = r_busy;
    assign event_cnt  = r_evt;

endmodule

// File: tb/tb_flag_capture_ctrl.sv
// Testbench for flag_capture_ctrl: a directed vector table, hand-written
// sequences for miss, saturation and mid-report reset, then randomized
// stimulus checked against a phase/timer reference model.
module tb_flag_capture_ctrl;

    localparam int SS     = 2;
    localparam int SETTLE = 3;
    localparam int HOLD   = 4;

    logic       clk;
    logic       rstn;
    logic       arm;
    logic       din_async;
    logic       flag_ack;

    logic       en_q, flag, flag_valid, miss, busy;
    logic [7:0] event_cnt;
    logic       en_q2, flag2, flag_valid2, miss2, busy2;
    logic [1:0] event_cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    flag_capture_ctrl #(
        .SYNC_STAGES  (SS),
        .SETTLE_CYCLES(SETTLE),
        .HOLD_CYCLES  (HOLD),
        .CNT_W        (8)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .arm       (arm),
        .din_async (din_async),
        .flag_ack  (flag_ack),
        .en_q      (en_q),
        .flag      (flag),
        .flag_valid(flag_valid),
        .miss      (miss),
        .busy      (busy),
        .event_cnt (event_cnt)
    );

    flag_capture_ctrl #(
        .SYNC_STAGES  (SS),
        .SETTLE_CYCLES(SETTLE),
        .HOLD_CYCLES  (HOLD),
        .CNT_W        (2)
    ) u_dut_sat (
        .clk       (clk),
        .rstn      (rstn),
        .arm       (arm),
        .din_async (din_async),
        .flag_ack  (flag_ack),
        .en_q      (en_q2),
        .flag      (flag2),
        .flag_valid(flag_valid2),
        .miss      (miss2),
        .busy      (busy2),
        .event_cnt (event_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_SETTLE, M_WATCH, M_REPORT, M_COOL} mphase_t;

    mphase_t m_ph;
    int      m_left;
    bit      m_flag;
    bit      m_miss;
    int      m_events;
    bit      m_hist[$];   // din samples, newest first

    function automatic void model_reset();
        m_ph     = M_IDLE;
        m_left   = 0;
        m_flag   = 1'b0;
        m_miss   = 1'b0;
        m_events = 0;
        m_hist.delete();
        for (int i = 0; i <= SS; i++) m_hist.push_back(1'b0);
    endfunction

    function automatic void model_edge(bit r, bit a, bit d, bit k);
        bit rise;
        if (!r) begin
            model_reset();
            return;
        end
        // din_s is the sample taken SS edges back; din_d one further.
        rise   = m_hist[SS-1] && !m_hist[SS];
        m_miss = rise && (m_ph == M_REPORT || m_ph == M_COOL);
        case (m_ph)
            M_IDLE:   if (a) begin m_ph = M_SETTLE; m_left = SETTLE - 1; end
            M_SETTLE: if (!a) m_ph = M_IDLE;
                      else if (m_left == 0) m_ph = M_WATCH;
                      else m_left--;
            M_WATCH:  if (!a) m_ph = M_IDLE;
                      else if (rise) begin m_flag = 1'b1; m_events++; m_ph = M_REPORT; end
            M_REPORT: if (k) begin m_flag = 1'b0; m_left = HOLD - 1; m_ph = M_COOL; end
            M_COOL:   if (m_left == 0) m_ph = a ? M_WATCH : M_IDLE;
                      else m_left--;
            default:  m_ph = M_IDLE;
        endcase
        m_hist.push_front(d);
        void'(m_hist.pop_back());
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic check_model();
        int e_act;
        e_act = (m_ph != M_IDLE) ? 1 : 0;
        chk("model_en_q",       en_q,        e_act);
        chk("model_busy",       busy,        e_act);
        chk("model_flag",       flag,        m_flag);
        chk("model_flag_valid", flag_valid,  m_flag);
        chk("model_miss",       miss,        m_miss);
        chk("model_event_cnt",  event_cnt,   sat(m_events, 255));
        chk("model_sat_en_q",   en_q2,       e_act);
        chk("model_sat_flag",   flag_valid2, m_flag);
        chk("model_sat_miss",   miss2,       m_miss);
        chk("model_sat_cnt",    event_cnt2,  sat(m_events, 3));
    endtask

    // One clock: inputs already driven; update model at the edge, sample 1ns later.
    task automatic tick();
        @(posedge clk);
        model_edge(rstn, arm, din_async, flag_ack);
        #1;
        check_model();
    endtask

    task automatic drive(input bit r, input bit a, input bit d, input bit k);
        rstn      = r;
        arm       = a;
        din_async = d;
        flag_ack  = k;
    endtask

    task automatic wait_flag(input string nm);
        int n;
        n = 0;
        while (!flag_valid && n < 20) begin
            tick();
            n++;
        end
        chk(nm, flag_valid, 1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rstn; bit arm; bit din; bit ack;
        bit en;   bit flg; bit mis; int cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit a, bit d, bit k, bit e, bit f, bit m, int c);
        vec_t v;
        v.rstn = r; v.arm = a; v.din = d; v.ack = k;
        v.en = e; v.flg = f; v.mis = m; v.cnt = c;
        return v;
    endfunction

    task automatic add(int n, bit r, bit a, bit d, bit k, bit e, bit f, bit m, int c);
        for (int i = 0; i < n; i++) vecs.push_back(mk(r, a, d, k, e, f, m, c));
    endtask

    int exp_sat[5];
    int misses;
    int c0;

    initial begin
        model_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0);

        // rstn arm din ack | en flag miss cnt
        add(3, 0, 1, 1, 0,  0, 0, 0, 0);  // held in reset with arm/din high
        add(1, 1, 0, 0, 0,  0, 0, 0, 0);  // released, unarmed: stays idle
        add(4, 1, 1, 0, 0,  1, 0, 0, 0);  // enter settle, three settle edges, watch
        add(2, 1, 1, 1, 0,  1, 0, 0, 0);  // din rising through synchroniser
        add(1, 1, 1, 1, 0,  1, 1, 0, 1);  // flag on third edge after din high
        add(5, 1, 1, 1, 0,  1, 1, 0, 1);  // no ack: flag held
        add(1, 1, 1, 0, 1,  1, 0, 0, 1);  // ack: flag clears, cooldown
        add(2, 1, 1, 1, 0,  1, 0, 0, 1);
        add(1, 1, 1, 1, 0,  1, 0, 1, 1);  // rise during cooldown -> miss
        add(2, 1, 1, 1, 0,  1, 0, 0, 1);  // cooldown ends, back to watch
        add(2, 1, 1, 0, 0,  1, 0, 0, 1);
        add(2, 1, 1, 1, 0,  1, 0, 0, 1);
        add(1, 1, 1, 1, 0,  1, 1, 0, 2);  // second capture
        add(1, 1, 0, 1, 0,  1, 1, 0, 2);  // disarm in report: held
        add(1, 1, 0, 1, 1,  1, 0, 0, 2);  // ack -> cooldown
        add(3, 1, 0, 1, 0,  1, 0, 0, 2);
        add(1, 1, 0, 1, 0,  0, 0, 0, 2);  // fourth cooldown edge -> idle
        add(1, 1, 1, 1, 0,  1, 0, 0, 2);  // arm -> settle
        add(1, 1, 0, 1, 0,  0, 0, 0, 2);  // disarm in settle -> idle

        foreach (vecs[i]) begin
            drive(vecs[i].rstn, vecs[i].arm, vecs[i].din, vecs[i].ack);
            tick();
            chk("tbl_en_q",       en_q,       vecs[i].en);
            chk("tbl_busy",       busy,       vecs[i].en);
            chk("tbl_flag",       flag,       vecs[i].flg);
            chk("tbl_flag_valid", flag_valid, vecs[i].flg);
            chk("tbl_miss",       miss,       vecs[i].mis);
            chk("tbl_event_cnt",  event_cnt,  vecs[i].cnt);
            chk("tbl_sat_cnt",    event_cnt2, vecs[i].cnt);
        end

        // ---- miss path: two synchronised rises while an event is outstanding
        drive(1, 1, 0, 0);
        repeat (8) tick();
        din_async = 1'b1;
        wait_flag("miss_seq_capture");
        c0 = event_cnt;
        misses = 0;
        for (int ph = 0; ph < 4; ph++) begin
            din_async = (ph % 2 == 1);
            for (int j = 0; j < 4; j++) begin
                tick();
                if (miss) misses++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            if (miss) misses++;
        end
        chk("miss_seq_pulses",  misses,     2);
        chk("miss_seq_cnt",     event_cnt,  c0);
        chk("miss_seq_flag",    flag_valid, 1);
        flag_ack = 1'b1;
        tick();
        flag_ack = 1'b0;
        chk("miss_seq_ack", flag_valid, 0);

        // ---- saturation on the 2-bit counter
        exp_sat = '{1, 2, 3, 3, 3};
        drive(0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 0);
        repeat (6) tick();
        for (int e = 0; e < 5; e++) begin
            din_async = 1'b1;
            wait_flag("sat_capture");
            chk("sat_cnt2", event_cnt2, exp_sat[e]);
            chk("sat_cnt8", event_cnt,  e + 1);
            flag_ack  = 1'b1;
            din_async = 1'b0;
            tick();
            flag_ack = 1'b0;
            repeat (6) tick();
        end

        // ---- reset while an event is being reported
        din_async = 1'b1;
        wait_flag("rst_seq_capture");
        drive(0, 1, 0, 1);
        tick();
        chk("rst_flag",       flag,       0);
        chk("rst_flag_valid", flag_valid, 0);
        chk("rst_event_cnt",  event_cnt,  0);
        chk("rst_en_q",       en_q,       0);
        chk("rst_busy",       busy,       0);
        chk("rst_miss",       miss,       0);
        drive(1, 0, 0, 0);
        tick();
        chk("rst_idle_busy", busy, 0);

        // ---- randomized run against the model
        arm = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rstn = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 39) == 0) arm = ~arm;
            if ($urandom_range(0, 5) == 0) din_async = ~din_async;
            flag_ack = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/flag_capture_ctrl.md
Name: flag_capture_ctrl

Overview:
- Sequencer for the enable-qualified flag-capture datapath: synchronises an asynchronous data input and drives a registered enable, so the qualifying condition never mixes an async input with a combinational enable.
- Runs a settle, watch, report and cooldown sequence. Delivers each captured event to a consumer over a valid/ack handshake and counts events.
- Sits between the control software/register block (arm) and the downstream event consumer.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on din_async (legal values 2..4).
- SETTLE_CYCLES, 3, cycles en_q must be high before rising edges are accepted (legal values >=1).
- HOLD_CYCLES, 4, cooldown cycles after each acknowledged event (legal values >=1).
- CNT_W, 8, width of event_cnt.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- arm  in  1  level; 1 requests watching.
- din_async  in  1  raw asynchronous event input.
- flag_ack  in  1  consumer accepts the flag.
- en_q  out  1  registered enable to the capture datapath.
- flag  out  1  registered captured-event flag.
- flag_valid  out  1  flag is presented to the consumer.
- miss  out  1  one-cycle pulse when a rise is dropped.
- busy  out  1  high in every state except IDLE.
- event_cnt  out  CNT_W  saturating count of captured events.

Behaviour:
- Reset: rstn, synchronous, active-low; clock clk. While rstn=0 at a clk edge, all flops clear. This covers the sync chain, the delay flop, the state (forced to IDLE), the counters, en_q, flag, flag_valid, miss, busy and event_cnt, which all go to 0. A reset mid-operation aborts any state immediately and drops pending flags without a miss pulse.
- Synchroniser: din_async passes through SYNC_STAGES flops to give din_s. A further flop gives din_d.
  - rise = din_s & ~din_d.
  - Latency: if din_async is high at edge E0, din_s is high after edge E(SYNC_STAGES-1) and flag is high after edge E(SYNC_STAGES).
- IDLE: en_q=0.
  - arm=1 -> SETTLE, load cnt=SETTLE_CYCLES-1, en_q<=1.
- SETTLE: en_q=1. Rises are ignored and do not pulse miss.
  - arm=0 -> IDLE, en_q<=0.
  - Otherwise, when cnt=0 -> WATCH; else cnt-1.
- WATCH: en_q=1.
  - arm=0 -> IDLE, en_q<=0. This check has priority over a same-cycle rise; that rise is lost silently.
  - rise=1 -> flag<=1, flag_valid<=1, event_cnt+1, -> REPORT. event_cnt holds at all-ones and never wraps.
- REPORT: flag and flag_valid are held stable until flag_ack=1 is sampled while flag_valid=1.
  - On that edge: flag<=0, flag_valid<=0, load cnt=HOLD_CYCLES-1, -> COOLDOWN.
  - A drop of arm during REPORT does not abort: the state still waits for ack, then goes to COOLDOWN. en_q stays 1 until leaving COOLDOWN.
  - Any rise during REPORT -> miss=1 for that cycle.
- COOLDOWN: any rise -> miss=1 pulse. When cnt=0 -> WATCH if arm=1, else IDLE with en_q<=0. Otherwise cnt-1.
- Outputs: busy is registered and equals (state != IDLE). miss is registered, high for exactly one cycle per dropped rise, and is 0 outside REPORT and COOLDOWN.
- flag_ack while flag_valid=0 is ignored.
- Simultaneous rise and ack in REPORT: the ack completes the current event and the rise is counted as a miss.

Test Plan:
- Reset/idle: hold rstn=0 for 3 cycles with arm=1 and din_async=1 -> all outputs 0. Release with arm=0 -> state stays IDLE, en_q=0, busy=0.
- Basic capture (defaults): arm=1 at cycle 0 -> en_q=1 from cycle 1 and WATCH after 3 settle cycles. Then raise din_async -> flag=1 and flag_valid=1 three edges later, event_cnt=1. Hold flag_ack=0 for 5 cycles -> flag stays 1. Pulse flag_ack -> flag=0 next edge, and a new rise is accepted only after 4 cooldown cycles.
- Miss path: toggle din_async 0->1->0->1 (4 cycles each) while in REPORT/COOLDOWN -> exactly one miss pulse per synchronised rise, event_cnt unchanged.
- Arm drop: drop arm during SETTLE -> IDLE next edge, en_q=0. Drop arm during REPORT -> flag_valid held until ack, then 4 cooldown cycles, then IDLE with en_q=0.
- Saturation: CNT_W=2, generate 5 accepted events -> event_cnt reads 1,2,3,3,3.
- Reset mid-REPORT: assert rstn=0 for one edge while flag_valid=1 -> flag=0, flag_valid=0, event_cnt=0, state IDLE, no miss pulse.
